// File: rtl/svo_tpgen_pkg.sv
// Shared definitions for the SVO test-pattern generator: pattern modes,
// colour-bar palette, ramp step and the xorshift32 update.
package svo_tpgen_pkg;

   typedef enum logic [2:0] {
      TP_SOLID   = 3'd0,
      TP_BARS    = 3'd1,
      TP_CHECKER = 3'd2,
      TP_RAMP    = 3'd3,
      TP_NOISE   = 3'd4
   } tp_mode_e;

   // Colour bars in {b,g,r}: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0] BAR_COLOR [8] = '{
      24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
      24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000
   };

   localparam int unsigned RAMP_STEP = 256;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] v;
      v = x ^ (x << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

endpackage

// File: rtl/svo_tpgen_if.sv
// AXI-stream video pixel bus between the pattern generator and its sink.
interface svo_tpgen_if #(
   parameter int BPP = 24
) ();
   logic           tvalid;
   logic           tready;
   logic [BPP-1:0] tdata;
   logic           tuser;

   modport master (output tvalid, output tdata, output tuser, input tready);
   modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/svo_xorshift32.sv
// xorshift32 noise source with seed load and step enable.
// next_state is the value the register takes on the coming step.
module svo_xorshift32
   import svo_tpgen_pkg::*;
#(
   parameter logic [31:0] RESET_SEED = 32'h075BCD15
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] state,
   output logic [31:0] next_state
);

   always_comb begin
      next_state = xorshift32(load ? seed : state);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= RESET_SEED;
      end else if (step) begin
         state <= next_state;
      end else if (load) begin
         state <= seed;
      end
   end

endmodule

// File: rtl/svo_tpgen.sv
// Multi-mode video test-pattern generator on an AXI-stream output.
// Mode, colour and border are latched at the (0,0) pixel so changes are frame-atomic.
module svo_tpgen
   import svo_tpgen_pkg::*;
#(
   parameter int          SVO_HOR_PIXELS     = 640,
   parameter int          SVO_VER_PIXELS     = 480,
   parameter int          SVO_BITS_PER_RED   = 8,
   parameter int          SVO_BITS_PER_GREEN = 8,
   parameter int          SVO_BITS_PER_BLUE  = 8,
   parameter int          CELL_LOG2          = 5,
   parameter int          XY_BITS            = 12,
   parameter logic [31:0] NOISE_SEED         = 32'h075BCD15
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [2:0]         mode,
   input  logic [23:0]        fg_color,
   input  logic               border_en,
   svo_tpgen_if.master        out_axis,
   output logic [15:0]        frame_cnt
);

   localparam int BPP = SVO_BITS_PER_RED + SVO_BITS_PER_GREEN + SVO_BITS_PER_BLUE;
   localparam logic [XY_BITS-1:0] H_LAST = XY_BITS'(SVO_HOR_PIXELS - 1);
   localparam logic [XY_BITS-1:0] V_LAST = XY_BITS'(SVO_VER_PIXELS - 1);
   localparam logic [XY_BITS-1:0] BAR_W  = XY_BITS'(SVO_HOR_PIXELS / 8);
   localparam logic [XY_BITS:0]   HOR_A  = (XY_BITS+1)'(SVO_HOR_PIXELS);
   localparam logic [XY_BITS:0]   STEP_A = (XY_BITS+1)'(RAMP_STEP);

   logic [XY_BITS-1:0] hcursor, vcursor, bar_cnt;
   logic [2:0]         bar_idx;
   logic [XY_BITS:0]   acc, acc_sum;
   logic [7:0]         level;
   logic [2:0]         mode_q, mode_e;
   logic [23:0]        fgc_q, fgc_e, pix24;
   logic               bord_q, bord_e;
   logic               adv, at_origin, h_last, v_last, on_edge;
   logic [31:0]        lfsr_state, lfsr_next;
   logic               lfsr_unused;

   function automatic logic [BPP-1:0] pack(input logic [23:0] c);
      return {c[23 -: SVO_BITS_PER_BLUE], c[15 -: SVO_BITS_PER_GREEN], c[7 -: SVO_BITS_PER_RED]};
   endfunction

   assign adv         = !out_axis.tvalid || out_axis.tready;
   assign h_last      = (hcursor == H_LAST);
   assign v_last      = (vcursor == V_LAST);
   assign at_origin   = (hcursor == '0) && (vcursor == '0);
   assign on_edge     = (hcursor == '0) || h_last || (vcursor == '0) || v_last;
   assign acc_sum     = acc + STEP_A;
   assign lfsr_unused = ^{lfsr_state, lfsr_next[31:24]};

   svo_xorshift32 #(
      .RESET_SEED (NOISE_SEED)
   ) u_noise (
      .clk        (clk),
      .resetn     (resetn),
      .load       (adv && at_origin),
      .step       (adv),
      .seed       (NOISE_SEED ^ {16'b0, frame_cnt}),
      .state      (lfsr_state),
      .next_state (lfsr_next)
   );

   // The origin pixel already uses the freshly sampled frame settings.
   always_comb begin
      mode_e = at_origin ? mode      : mode_q;
      fgc_e  = at_origin ? fg_color  : fgc_q;
      bord_e = at_origin ? border_en : bord_q;
      case (mode_e)
         TP_BARS:    pix24 = BAR_COLOR[bar_idx];
         TP_CHECKER: pix24 = (hcursor[CELL_LOG2] ^ vcursor[CELL_LOG2]) ? fgc_e : '0;
         TP_RAMP:    pix24 = {level, level, level};
         TP_NOISE:   pix24 = lfsr_next[23:0];
         default:    pix24 = fgc_e;
      endcase
      if (bord_e && on_edge) begin
         pix24 = '1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_axis.tvalid <= 1'b0;
         out_axis.tdata  <= '0;
         out_axis.tuser  <= 1'b0;
         frame_cnt       <= '0;
         hcursor         <= '0;
         vcursor         <= '0;
         mode_q          <= '0;
         fgc_q           <= '0;
         bord_q          <= 1'b0;
         acc             <= '0;
         level           <= '0;
         bar_idx         <= '0;
         bar_cnt         <= '0;
      end else if (adv) begin
         out_axis.tvalid <= 1'b1;
         out_axis.tdata  <= pack(pix24);
         out_axis.tuser  <= at_origin;
         if (at_origin) begin
            mode_q <= mode;
            fgc_q  <= fg_color;
            bord_q <= border_en;
         end
         if (h_last) begin
            hcursor <= '0;
            acc     <= '0;
            level   <= '0;
            bar_idx <= '0;
            bar_cnt <= '0;
            if (v_last) begin
               vcursor   <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               vcursor <= vcursor + XY_BITS'(1);
            end
         end else begin
            hcursor <= hcursor + XY_BITS'(1);
            // HOR >= 256 keeps acc+256 below 2*HOR, so one subtraction suffices.
            if (acc_sum >= HOR_A) begin
               acc   <= acc_sum - HOR_A;
               level <= level + 8'd1;
            end else begin
               acc <= acc_sum;
            end
            if (bar_cnt == BAR_W - XY_BITS'(1) && bar_idx != 3'd7) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + XY_BITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_svo_tpgen.sv
// Self-checking bench for svo_tpgen: frame-level pixel model checked every cycle
// plus directed literal expectations at selected beats.
module tb_svo_tpgen;

   localparam int          HOR  = 256;
   localparam int          VER  = 4;
   localparam int          CELL = 1;
   localparam logic [31:0] SEED = 32'h075BCD15;

   logic        clk       = 1'b0;
   logic        resetn    = 1'b0;
   logic [2:0]  mode      = 3'd0;
   logic [23:0] fg_color  = 24'h0;
   logic        border_en = 1'b0;
   logic [15:0] frame_cnt;

   int tests = 0;
   int fails = 0;

   svo_tpgen_if #(.BPP(24)) axis ();

   svo_tpgen #(
      .SVO_HOR_PIXELS     (HOR),
      .SVO_VER_PIXELS     (VER),
      .SVO_BITS_PER_RED   (8),
      .SVO_BITS_PER_GREEN (8),
      .SVO_BITS_PER_BLUE  (8),
      .CELL_LOG2          (CELL),
      .XY_BITS            (12),
      .NOISE_SEED         (SEED)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mode      (mode),
      .fg_color  (fg_color),
      .border_en (border_en),
      .out_axis  (axis),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                             24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
   logic        exp_valid = 1'b0;
   logic        exp_user  = 1'b0;
   logic [23:0] exp_data  = 24'h0;
   logic [15:0] exp_fcnt  = 16'h0;
   int          m_x = 0, m_y = 0, pres_x = 0, pres_y = 0;
   logic [2:0]  lat_mode = 3'd0;
   logic [23:0] lat_fg   = 24'h0;
   logic        lat_b    = 1'b0;
   logic [31:0] lfsr     = 32'h0;

   function automatic logic [31:0] xs(input logic [31:0] x);
      logic [31:0] v;
      v = x ^ (x << 13);
      v = v ^ (v >> 17);
      return v ^ (v << 5);
   endfunction

   function automatic logic [23:0] model_pixel(input int x, input int y);
      int b;
      logic [7:0] lv;
      if (lat_b && (x == 0 || x == HOR-1 || y == 0 || y == VER-1)) return 24'hFFFFFF;
      case (lat_mode)
         3'd1: begin
            b = x / (HOR / 8);
            if (b > 7) b = 7;
            return bars[b];
         end
         3'd2: return ((((x >> CELL) ^ (y >> CELL)) & 1) != 0) ? lat_fg : 24'h0;
         3'd3: begin
            lv = 8'((256 * x) / HOR);
            return {lv, lv, lv};
         end
         3'd4: return lfsr[23:0];
         default: return lat_fg;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare the current beat, then predict what the next edge will present.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_valid = 1'b0; exp_user = 1'b0; exp_data = 24'h0; exp_fcnt = 16'h0;
         m_x = 0; m_y = 0; pres_x = 0; pres_y = 0;
      end
      check("tvalid",    32'(axis.tvalid), 32'(exp_valid));
      check("tdata",     32'(axis.tdata),  32'(exp_data));
      check("tuser",     32'(axis.tuser),  32'(exp_user));
      check("frame_cnt", 32'(frame_cnt),   32'(exp_fcnt));
      if (resetn && (!exp_valid || axis.tready)) begin
         if (m_x == 0 && m_y == 0) begin
            lat_mode = mode; lat_fg = fg_color; lat_b = border_en;
            lfsr = SEED ^ {16'h0, exp_fcnt};
         end
         lfsr      = xs(lfsr);
         exp_data  = model_pixel(m_x, m_y);
         exp_user  = (m_x == 0 && m_y == 0);
         exp_valid = 1'b1;
         pres_x    = m_x;
         pres_y    = m_y;
         m_x++;
         if (m_x == HOR) begin
            m_x = 0;
            m_y++;
            if (m_y == VER) begin
               m_y = 0;
               exp_fcnt++;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_pix(input int x, input int y);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1 axis.tready = 1'($urandom_range(0, 1));
         #1 n++;
      end while (!(exp_valid && pres_x == x && pres_y == y) && n < 5000);
      if (n >= 5000) begin
         tests++;
         fails++;
         $display("FAIL wait_pix(%0d,%0d): beat not seen within 5000 cycles", x, y);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      axis.tready = 1'b0;
      fg_color    = 24'h123456;
      repeat (3) @(posedge clk);
      #2;
      check("rst_tvalid", 32'(axis.tvalid), 32'h0);
      check("rst_tdata",  32'(axis.tdata),  32'h0);
      check("rst_tuser",  32'(axis.tuser),  32'h0);
      check("rst_fcnt",   32'(frame_cnt),   32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // solid colour, random backpressure
      wait_pix(0, 0);
      check("solid_p0",    32'(axis.tdata), 32'h123456);
      check("solid_tuser", 32'(axis.tuser), 32'h1);
      wait_pix(255, 3);
      check("solid_last_tuser", 32'(axis.tuser), 32'h0);
      wait_pix(0, 0);
      check("solid_fcnt1", 32'(frame_cnt), 32'h1);
      check("solid_tuser1", 32'(axis.tuser), 32'h1);

      // colour bars with a stall
      wait_pix(1, 0);
      mode = 3'd1;
      wait_pix(0, 0);
      check("bars_x0", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(31, 0);
      check("bars_x31", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(32, 0);
      check("bars_x32", 32'(axis.tdata), 32'h00FFFF);
      axis.tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2 check("bars_stall", 32'(axis.tdata), 32'h00FFFF);
      end
      wait_pix(63, 0);
      check("bars_x63", 32'(axis.tdata), 32'h00FFFF);
      wait_pix(224, 0);
      check("bars_x224", 32'(axis.tdata), 32'h000000);

      // grey ramp
      mode = 3'd3;
      wait_pix(0, 0);
      check("ramp_x0", 32'(axis.tdata), 32'h000000);
      wait_pix(100, 1);
      check("ramp_x100", 32'(axis.tdata), 32'h646464);
      wait_pix(255, 1);
      check("ramp_x255", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(0, 2);
      check("ramp_line_restart", 32'(axis.tdata), 32'h000000);

      // checker, mid-frame mode change ignored
      mode     = 3'd2;
      fg_color = 24'hFFFFFF;
      wait_pix(0, 0);
      check("chk_0_0", 32'(axis.tdata), 32'h000000);
      wait_pix(1, 0);
      mode = 3'd0;
      wait_pix(2, 0);
      check("chk_2_0", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(0, 2);
      check("chk_0_2", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(2, 2);
      check("chk_2_2", 32'(axis.tdata), 32'h000000);
      wait_pix(0, 0);
      check("solid_after_chk", 32'(axis.tdata), 32'hFFFFFF);

      // noise: two frames, then reproducibility after reset
      mode = 3'd4;
      pulse_reset();
      wait_pix(0, 0);
      check("noise_f0_p0", 32'(axis.tdata), 32'hD31F49);
      check("noise_fcnt0", 32'(frame_cnt),  32'h0);
      wait_pix(255, 3);
      wait_pix(0, 0);
      check("noise_fcnt1", 32'(frame_cnt), 32'h1);
      pulse_reset();
      wait_pix(0, 0);
      check("noise_repeat_p0", 32'(axis.tdata), 32'hD31F49);

      // border overlay and mid-frame async reset
      border_en = 1'b1;
      mode      = 3'd0;
      fg_color  = 24'h000000;
      wait_pix(1, 0);
      wait_pix(0, 0);
      check("bord_0_0", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(5, 0);
      check("bord_5_0", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(0, 1);
      check("bord_0_1", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(5, 1);
      check("bord_5_1", 32'(axis.tdata), 32'h000000);
      wait_pix(44, 1);
      #1 resetn = 1'b0;
      #1 check("async_rst_tvalid", 32'(axis.tvalid), 32'h0);
      @(posedge clk);
      #1 resetn = 1'b1;
      wait_pix(0, 0);
      check("post_rst_tuser", 32'(axis.tuser), 32'h1);
      check("post_rst_tdata", 32'(axis.tdata), 32'hFFFFFF);
      check("post_rst_fcnt",  32'(frame_cnt),  32'h0);
      wait_pix(255, 2);
      check("bord_255_2", 32'(axis.tdata), 32'hFFFFFF);
      wait_pix(7, 3);
      check("bord_7_3", 32'(axis.tdata), 32'hFFFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
